// File: rtl/mac_pipe_acc.sv
// rtl/mac_pipe_acc.sv - pipelined signed/unsigned multiply-accumulate with wrap or saturate
module mac_pipe_acc #(
   parameter int A_WIDTH   = 16,
   parameter int B_WIDTH   = 16,
   parameter int ACC_WIDTH = 40,
   parameter int A_SIGNED  = 1,
   parameter int B_SIGNED  = 1,
   parameter int MUL_PIPE  = 2,
   parameter int SATURATE  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic                 in_last,
   input  logic [A_WIDTH-1:0]   a,
   input  logic [B_WIDTH-1:0]   b,
   output logic                 out_valid,
   output logic [ACC_WIDTH-1:0] acc,
   output logic                 ovf
);
   localparam int AX_W = A_WIDTH + 1;
   localparam int BX_W = B_WIDTH + 1;
   localparam int P_W  = AX_W + BX_W;
   // two guard bits above the accumulator so running + product never wraps internally
   localparam int S_W  = ACC_WIDTH + 2;
   localparam bit ACC_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

   logic [A_WIDTH-1:0] a_q;
   logic [B_WIDTH-1:0] b_q;
   logic               v_q, f_q, l_q;

   // input register: capture operands and frame flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         v_q <= 1'b0;
         f_q <= 1'b0;
         l_q <= 1'b0;
      end else if (ce) begin
         a_q <= a;
         b_q <= b;
         v_q <= in_valid;
         f_q <= in_first;
         l_q <= in_last;
      end
   end

   logic signed [AX_W-1:0] a_x;
   logic signed [BX_W-1:0] b_x;
   logic signed [P_W-1:0]  prod;

   // extend each operand by one bit per its signedness, then one signed multiply covers all modes
   always_comb begin
      a_x  = (A_SIGNED != 0) ? {a_q[A_WIDTH-1], a_q} : {1'b0, a_q};
      b_x  = (B_SIGNED != 0) ? {b_q[B_WIDTH-1], b_q} : {1'b0, b_q};
      prod = P_W'(a_x) * P_W'(b_x);
   end

   logic signed [P_W-1:0] p_q [MUL_PIPE];
   logic [MUL_PIPE-1:0]   pv_q, pf_q, pl_q;

   // product pipeline: stage 0 registers the multiplier output, later stages just delay it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MUL_PIPE; i++) p_q[i] <= '0;
         pv_q <= '0;
         pf_q <= '0;
         pl_q <= '0;
      end else if (ce) begin
         p_q[0]  <= prod;
         pv_q[0] <= v_q;
         pf_q[0] <= f_q;
         pl_q[0] <= l_q;
         for (int i = 1; i < MUL_PIPE; i++) begin
            p_q[i]  <= p_q[i-1];
            pv_q[i] <= pv_q[i-1];
            pf_q[i] <= pf_q[i-1];
            pl_q[i] <= pl_q[i-1];
         end
      end
   end

   logic [ACC_WIDTH-1:0]  run_q;
   logic                  stk_q;
   logic signed [S_W-1:0] prod_x, run_x, base, sum;
   logic [2:0]            sum_top;
   logic [ACC_WIDTH-1:0]  sat_val, res;
   logic                  ovf_now, stk_next;
   logic                  pv, pf, pl;

   // accumulate: add product to running value (or restart on first), detect and resolve overflow
   always_comb begin
      pv      = pv_q[MUL_PIPE-1];
      pf      = pf_q[MUL_PIPE-1];
      pl      = pl_q[MUL_PIPE-1];
      prod_x  = S_W'(p_q[MUL_PIPE-1]);
      if (ACC_SIGNED) run_x = S_W'($signed(run_q));
      else            run_x = S_W'(run_q);
      base    = pf ? '0 : run_x;
      sum     = base + prod_x;
      sum_top = sum[S_W-1:ACC_WIDTH-1];
      if (ACC_SIGNED) begin
         ovf_now = !((sum_top == 3'b000) || (sum_top == 3'b111));
         sat_val = sum[S_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
         ovf_now = |sum[S_W-1:ACC_WIDTH];
         sat_val = '1;
      end
      res      = (ovf_now && (SATURATE != 0)) ? sat_val : sum[ACC_WIDTH-1:0];
      stk_next = (pf ? 1'b0 : stk_q) | ovf_now;
   end

   // running accumulator, sticky overflow and frame result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= '0;
         stk_q     <= 1'b0;
         acc       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (ce) begin
         out_valid <= pv & pl;
         if (pv) begin
            run_q <= res;
            stk_q <= stk_next;
            if (pl) begin
               acc <= res;
               ovf <= stk_next;
            end
         end
      end
   end
endmodule
